// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for the async FIFO: prefetches into a 3-entry skid buffer and
// presents a registered valid/ready stream, with a delivered-beat counter and flush.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   read_en,
    input  logic                   flush,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    typedef logic [1:0] ptr_t;

    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic [1:0]            occ;
    logic                  inflight;
    ptr_t                  head;
    ptr_t                  tail;

    logic                  ret;
    logic                  pop;
    logic [1:0]            occ_next;
    ptr_t                  head_next;
    ptr_t                  tail_next;
    logic [DATA_WIDTH-1:0] head_data_next;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one in flight must fit in the 3 slots, so a
    // read is never issued that could overflow; out_ready is deliberately absent.
    assign read_en = !reset && !flush && !fifo_empty
                     && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
    assign ret     = inflight && !flush;
    assign pop     = out_valid && out_ready;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        if (ret) tail_next = ptr_inc(tail);
        if (pop) head_next = ptr_inc(head);
        case ({ret, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
        // A returning word becomes the new head only when the buffer drains to it.
        head_data_next = (ret && (tail == head_next)) ? fifo_data : buf_mem[head_next];
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ        <= 2'd0;
            head       <= 2'd0;
            tail       <= 2'd0;
            inflight   <= 1'b0;
            out_valid  <= 1'b0;
            beat_count <= '0;
        end else begin
            inflight <= read_en;
            if (pop) beat_count <= beat_count + COUNT_WIDTH'(1);
            if (flush) begin
                occ       <= 2'd0;
                head      <= 2'd0;
                tail      <= 2'd0;
                out_valid <= 1'b0;
            end else begin
                occ       <= occ_next;
                head      <= head_next;
                tail      <= tail_next;
                out_valid <= (occ_next != 2'd0);
                if (occ_next != 2'd0) out_data <= head_data_next;
            end
        end
    end

    // NOTE: buffer storage is not reset; occ and the pointers alone define its contents.
    always_ff @(posedge clock) begin
        if (!reset && ret) buf_mem[tail] <= fifo_data;
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench: behavioural FIFO read port with 1-cycle latency, a per-cycle
// vector table for reset/empty/fill/drain, and directed multi-cycle sequences.
module tb_fifo_rd_stream_adapter;

    logic        clock = 1'b0;
    logic        reset;
    logic        force_empty;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        read_en;
    logic        flush;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] beat_count;

    logic        rst4;
    logic        ready4;
    logic        ready4_next;
    logic        read_en4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic [3:0]  beat_count4;

    logic [7:0]  src [2048];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    int          exp_idx, beats, beats4, rd_pulses, cyc, viol;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clock = ~clock;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    // Behavioural FIFO read port: data appears the cycle after read_en.
    always @(posedge clock) begin
        if (read_en === 1'b1) begin
            fifo_data <= src[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    fifo_rd_stream_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .read_en(read_en), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .beat_count(beat_count)
    );

    fifo_rd_stream_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(rst4), .fifo_empty(1'b0), .fifo_data(8'hA5),
        .read_en(read_en4), .flush(1'b0), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(ready4), .beat_count(beat_count4)
    );

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        fl;
        logic        exp_rd;
        logic        exp_valid;
        logic [15:0] exp_beat;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later.
    task automatic cycle(input logic rst, input logic fe, input logic rdy, input logic fl);
        @(negedge clock);
        reset = rst; force_empty = fe; out_ready = rdy; flush = fl; ready4 = ready4_next;
        #1;
        cyc++;
        if (read_en === 1'b1) rd_pulses++;
        if (read_en === 1'b1 && fifo_empty) viol++;
        if (dut.inflight === 1'b1 && dut.occ == 2'd3) viol++;
        if (out_valid === 1'b1 && out_ready) begin
            check($sformatf("beat_data[%0d]", exp_idx), {24'd0, out_data}, {24'd0, src[exp_idx]});
            exp_idx++;
            beats++;
        end
        if (out_valid4 === 1'b1 && ready4) beats4++;
    endtask

    task automatic new_test(input int n);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        wr_ptr    = rd_ptr + n;
        exp_idx   = rd_ptr;
        beats     = 0;
        rd_pulses = 0;
        cyc       = 0;
    endtask

    initial begin
        int first_rd, first_valid, last_beat;
        reset = 1'b1; force_empty = 1'b1; flush = 1'b0; out_ready = 1'b0;
        rst4 = 1'b1; ready4 = 1'b0; ready4_next = 1'b0; viol = 0; beats4 = 0;
        for (int i = 0; i < 2048; i++) src[i] = 8'($urandom);

        // Reset, 10 empty cycles, then fill 4 words with out_ready low and drain.
        for (int i = 0; i < 10; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4};

        new_test(4);
        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].fl);
            check($sformatf("tbl%0d_read_en", i), read_en, vecs[i].exp_rd);
            check($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("tbl%0d_beat_count", i), beat_count, vecs[i].exp_beat);
        end
        check("tbl_beats", beats, 4);

        // Streaming 32 words with out_ready held high.
        new_test(32);
        first_rd = -1; first_valid = -1; last_beat = -1;
        for (int k = 0; k < 60; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (read_en && first_rd < 0) first_rd = cyc;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid) last_beat = cyc;
        end
        check("stream_first_latency", first_valid - first_rd, 2);
        check("stream_beats", beats, 32);
        check("stream_back_to_back", last_beat - first_valid, 31);
        check("stream_beat_count", beat_count, 32);

        // Backpressure: exactly 3 reads, then drain in order and resume.
        new_test(8);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_read_pulses", rd_pulses, 3);
        check("bp_occ", dut.occ, 3);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_held", out_data, src[exp_idx]);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_release_read_en", read_en, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_resume_read_en", read_en, 1);
        for (int k = 0; k < 50 && beats < 8; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_beats", beats, 8);
        check("bp_beat_count", beat_count, 8);

        // Random out_ready and pessimistic empty over 1000 words.
        new_test(1000);
        for (int k = 0; k < 8000 && beats < 1000; k++)
            cycle(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rand_beats", beats, 1000);
        check("rand_beat_count", beat_count, 1000);

        // Flush with occ=2 and one word in flight, then flush while popping.
        new_test(20);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("fl_occ_before", dut.occ, 2);
        check("fl_inflight_before", dut.inflight, 1);
        check("fl_read_en", read_en, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("fl_out_valid", out_valid, 0);
        check("fl_beat_count", beat_count, 0);
        exp_idx += 3;
        for (int k = 0; k < 30 && beats < 4; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("fl_post_beats", beats, 4);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("fl2_occ_before", dut.occ, 1);
        check("fl2_inflight_before", dut.inflight, 1);
        exp_idx += 1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("fl2_out_valid", out_valid, 0);
        check("fl2_pop_counted", beat_count, 5);
        for (int k = 0; k < 30 && beats < 9; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("fl2_post_beats", beats, 9);

        // 4-bit beat counter wraps after 16 beats.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        rst4 = 1'b0;
        ready4_next = 1'b1;
        for (int k = 0; k < 60 && beats4 < 17; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        ready4_next = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("wrap_beats", beats4, 17);
        check("wrap_beat_count", beat_count4, 1);

        check("no_overflow_or_empty_read", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream_adapter.md
# fifo_rd_stream_adapter

Read-side companion to the asynchronous FIFO: it drives the FIFO's `read_en` / `data_out` / `fifo_empty` read port in the read clock domain and turns it into a registered valid/ready stream for downstream logic. It prefetches words into a 3-entry skid buffer, which hides the FIFO's 1-cycle read latency and sustains one word per cycle with no combinational path from `out_ready` to `read_en`. It also counts delivered beats and supports a synchronous flush.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and stream data.
- `COUNT_WIDTH`, 16, width of the delivered-beat counter.

Ports:
- `clock`  in  1  read-domain clock; same clock as the FIFO read port.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid 1 cycle after `read_en`.
- `read_en`  out  1  FIFO read enable.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `out_data`  out  DATA_WIDTH  stream data; the buffer head, registered.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.
- `beat_count`  out  COUNT_WIDTH  number of accepted stream beats, wrapping.

## Operation
**State**
- `occ`: 0..3, the number of buffered words.
- `inflight`: 1 bit, registered copy of `read_en`.
- 3-entry circular buffer with head and tail pointers mod 3 (2→0 wrap).
- `beat_count`.

**Read issue**
- `read_en = !reset && !flush && !fifo_empty && (occ + inflight) < 3`.
- `read_en` is purely a function of registered state plus `fifo_empty`; it never depends on `out_ready`.

**Return**
- If `inflight` = 1 and `flush` = 0, `fifo_data` is written at the tail, the tail advances, and `occ` is incremented.

**Pop**
- `pop = out_valid && out_ready`; the head advances and `occ` is decremented.
- `out_valid = (occ != 0)`. `out_data` = the head entry.
- When `occ` = 0, `out_data` holds its last value (don't-care).

**Simultaneous events**
- Return and pop in the same cycle: `occ` is unchanged and FIFO order is preserved.
- Return while `occ` = 3 cannot occur by construction. Verification asserts this.

**Beat counter**
- `beat_count` increments by 1 on every pop and wraps from 2^COUNT_WIDTH−1 to 0.
- It is not cleared by `flush`.

**Flush**
- Next cycle: `occ` = 0, pointers = 0, `inflight` = 0, `out_valid` = 0.
- A word returning in the flush cycle (from `read_en` in the previous cycle) is discarded.
- A pop in the flush cycle still counts.
- `read_en` is 0 during the flush cycle.

**Reset**
- Values after reset: `occ` = 0, pointers = 0, `inflight` = 0, `beat_count` = 0, `out_valid` = 0.
- `read_en` = 0 while `reset` is high.
- A word in flight when `reset` asserts is discarded. The FIFO pointer has already advanced, so that word is lost. This is intended behaviour.

**`fifo_empty` misuse**
- `read_en` is never asserted while `fifo_empty` = 1, even though the empty flag is pessimistic (synchronized write pointer).

## Timing
- `read_en` high in cycle N → `fifo_data` valid in N+1 → captured at the end of N+1 → `out_valid` = 1 in N+2.
- First-word latency from `fifo_empty` falling (buffer empty): 2 cycles.
- Steady state with `out_ready` = 1 and FIFO non-empty: 1 beat/cycle; `occ` settles at 1 and `inflight` at 1.
- `out_ready` low: reads continue until `occ + inflight` = 3. At most 3 words are buffered and 0 words are lost.
- `out_ready` reasserted after a stall: a beat is delivered in the same cycle, and `read_en` resumes the following cycle.
- All outputs except `read_en` are registered. `read_en` is combinational from registered state, `fifo_empty`, `flush` and `reset`.

## Test plan
1. **Reset and empty.** Drive `reset` = 1 for 2 cycles, then `fifo_empty` = 1 for 10 cycles → `read_en` = 0, `out_valid` = 0 and `beat_count` = 0 throughout.
2. **Streaming.** Feed words 0x01..0x20 with `out_ready` = 1 → `out_data` sequence 0x01..0x20 in order; first `out_valid` 2 cycles after the first `read_en`; then 1 beat/cycle; `beat_count` = 32.
3. **Backpressure.** Hold `out_ready` = 0 with the FIFO non-empty → exactly 3 `read_en` pulses, `occ` = 3, `out_data` = first word held. Release → 3 buffered words drain in order, then reading resumes, with no loss or duplication.
4. **Random `out_ready`.** Toggle `out_ready` randomly (50%) over 1000 words → output equals input order, `beat_count` = 1000 mod 2^16, and the no-overflow assertion never fires.
5. **Flush mid-stream.** Pulse `flush` for 1 cycle with `occ` = 2 and `inflight` = 1 → next cycle `out_valid` = 0 and the 3 words are dropped; the next delivered word is the 4th FIFO word read after flush; `beat_count` is unchanged by the flush.
6. **Counter wrap.** Set `COUNT_WIDTH` = 4 and deliver 17 beats → `beat_count` = 1.
